// File: rtl/maxpool_layer.sv
// rtl/maxpool_layer.sv - POOL_DIM x POOL_DIM stride-POOL_DIM max pooling of IEEE-754 doubles over an upstream memory
module maxpool_layer #(
    parameter string NAME         = "MAXPOOL",
    parameter int    NUM_CHANNELS = 16,
    parameter int    INPUT_DIM    = 26,
    parameter int    POOL_DIM     = 2,
    parameter int    DATA_SIZE    = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 compute,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic [2:0][15:0]     read_inmem_index,
    input  logic [2:0][15:0]     read_outmem_index,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 busy,
    output logic                 output_valid
);
    localparam int OUTPUT_DIM = INPUT_DIM / POOL_DIM;
    localparam int TOTAL      = NUM_CHANNELS * OUTPUT_DIM * OUTPUT_DIM;
    localparam int AW         = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic [15:0] ch, orow, ocol, wr, wc;
    logic        wc_last, wr_last, ocol_last, orow_last, ch_last, read_last;

    logic                 d_valid, d_first, d_last;
    logic [AW-1:0]        d_addr;
    logic [DATA_SIZE-1:0] acc, win;

    logic [DATA_SIZE-1:0] mem [TOTAL];
    logic [AW-1:0]        rd_addr;
    logic                 rd_in_range;

    // Raw-bit double ordering; both zeros compare equal so the earlier element is kept.
    function automatic logic greater(input logic [DATA_SIZE-1:0] a, input logic [DATA_SIZE-1:0] b);
        logic [DATA_SIZE-2:0] ma, mb;
        ma = a[DATA_SIZE-2:0];
        mb = b[DATA_SIZE-2:0];
        if (ma == '0 && mb == '0)
            return 1'b0;
        if (a[DATA_SIZE-1] != b[DATA_SIZE-1])
            return !a[DATA_SIZE-1];
        if (!a[DATA_SIZE-1])
            return ma > mb;
        return ma < mb;
    endfunction

    assign wc_last   = (wc   == 16'(POOL_DIM - 1));
    assign wr_last   = (wr   == 16'(POOL_DIM - 1));
    assign ocol_last = (ocol == 16'(OUTPUT_DIM - 1));
    assign orow_last = (orow == 16'(OUTPUT_DIM - 1));
    assign ch_last   = (ch   == 16'(NUM_CHANNELS - 1));
    assign read_last = wc_last && wr_last && ocol_last && orow_last && ch_last;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next   = state;
        busy         = 1'b0;
        output_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (compute)
                    state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (read_last)
                    state_next = DRAIN;
            end
            DRAIN: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                output_valid = 1'b1;
                if (compute)
                    state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters sit at zero outside RUN, so the first read of a run is index 0.
    always_ff @(posedge clk) begin
        if (reset || state != RUN) begin
            ch   <= '0;
            orow <= '0;
            ocol <= '0;
            wr   <= '0;
            wc   <= '0;
        end else begin
            wc <= wc_last ? 16'd0 : wc + 16'd1;
            if (wc_last) begin
                wr <= wr_last ? 16'd0 : wr + 16'd1;
                if (wr_last) begin
                    ocol <= ocol_last ? 16'd0 : ocol + 16'd1;
                    if (ocol_last) begin
                        orow <= orow_last ? 16'd0 : orow + 16'd1;
                        if (orow_last)
                            ch <= ch_last ? 16'd0 : ch + 16'd1;
                    end
                end
            end
        end
    end

    assign read_inmem_index[2] = ch;
    assign read_inmem_index[1] = orow * 16'(POOL_DIM) + wr;
    assign read_inmem_index[0] = ocol * 16'(POOL_DIM) + wc;

    // Window bookkeeping travels one cycle behind the index to line up with in_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_valid <= 1'b0;
            d_first <= 1'b0;
            d_last  <= 1'b0;
            d_addr  <= '0;
        end else begin
            d_valid <= (state == RUN);
            d_first <= (wr == 16'd0) && (wc == 16'd0);
            d_last  <= wr_last && wc_last;
            d_addr  <= AW'(ch) * AW'(OUTPUT_DIM * OUTPUT_DIM) + AW'(orow) * AW'(OUTPUT_DIM) + AW'(ocol);
        end
    end

    assign win = (d_first || greater(in_data, acc)) ? in_data : acc;

    always_ff @(posedge clk) begin
        if (d_valid)
            acc <= win;
        if (d_valid && d_last)
            mem[d_addr] <= win;
    end

    assign rd_in_range = (read_outmem_index[2] < 16'(NUM_CHANNELS)) &&
                         (read_outmem_index[1] < 16'(OUTPUT_DIM)) &&
                         (read_outmem_index[0] < 16'(OUTPUT_DIM));
    assign rd_addr = AW'(read_outmem_index[2]) * AW'(OUTPUT_DIM * OUTPUT_DIM) +
                     AW'(read_outmem_index[1]) * AW'(OUTPUT_DIM) + AW'(read_outmem_index[0]);

    always_ff @(posedge clk) begin
        if (reset)
            out_data <= '0;
        else
            out_data <= rd_in_range ? mem[rd_addr] : '0;
    end
endmodule

// File: tb/tb_maxpool_layer.sv
// tb/tb_maxpool_layer.sv - self-checking bench for maxpool_layer with a real-valued reference model
module tb_maxpool_layer;
    localparam int C  = 2;
    localparam int D  = 5;
    localparam int P  = 2;
    localparam int OD = D / P;
    localparam int N  = C * OD * OD * P * P;

    logic             clk = 1'b0;
    logic             reset;
    logic             compute;
    logic [63:0]      in_data;
    logic [2:0][15:0] read_inmem_index;
    logic [2:0][15:0] read_outmem_index;
    logic [63:0]      out_data;
    logic             busy;
    logic             output_valid;

    int tests = 0;
    int fails = 0;

    logic [63:0]      up_mem  [C][D][D];
    logic [63:0]      exp_mem [C][OD][OD];
    logic [2:0][15:0] exp_idx [$];

    typedef struct {
        int          c;
        int          r;
        int          col;
        logic [63:0] exp;
        string       name;
    } vec_t;
    vec_t vecs [$];

    maxpool_layer #(
        .NAME("MAXPOOL"), .NUM_CHANNELS(C), .INPUT_DIM(D), .POOL_DIM(P), .DATA_SIZE(64)
    ) dut (
        .clk(clk), .reset(reset), .compute(compute), .in_data(in_data),
        .read_inmem_index(read_inmem_index), .read_outmem_index(read_outmem_index),
        .out_data(out_data), .busy(busy), .output_valid(output_valid)
    );

    always #5 clk = ~clk;

    // Upstream memory: registered read, one cycle latency.
    always @(posedge clk) begin
        int ci, ri, ki;
        ci = int'(read_inmem_index[2]);
        ri = int'(read_inmem_index[1]);
        ki = int'(read_inmem_index[0]);
        if (ci < C && ri < D && ki < D)
            in_data <= up_mem[ci][ri][ki];
        else
            in_data <= 64'd0;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] rand_dbl();
        logic [63:0] v;
        int sel;
        sel = $urandom_range(0, 9);
        v = {$urandom, $urandom};
        if (sel == 0)
            v[62:0] = '0;
        else if (sel == 1)
            v[62:0] = {11'h7FF, 52'd0};
        else if (v[62:52] == 11'h7FF)
            v[62:52] = 11'h7FE;
        return v;
    endfunction

    // Reference: plain real comparison in raster order, first wins on equality.
    task automatic build_model();
        for (int c = 0; c < C; c++)
            for (int r = 0; r < OD; r++)
                for (int k = 0; k < OD; k++) begin
                    logic [63:0] best;
                    best = up_mem[c][r*P][k*P];
                    for (int wr = 0; wr < P; wr++)
                        for (int wc = 0; wc < P; wc++)
                            if ($bitstoreal(up_mem[c][r*P+wr][k*P+wc]) > $bitstoreal(best))
                                best = up_mem[c][r*P+wr][k*P+wc];
                    exp_mem[c][r][k] = best;
                end
    endtask

    task automatic fill_random();
        for (int c = 0; c < C; c++)
            for (int r = 0; r < D; r++)
                for (int k = 0; k < D; k++)
                    up_mem[c][r][k] = rand_dbl();
    endtask

    task automatic read_check(input int c, input int r, input int k, input logic [63:0] exp, input string name);
        @(negedge clk);
        read_outmem_index = {16'(c), 16'(r), 16'(k)};
        @(negedge clk);
        check(name, out_data, exp);
    endtask

    task automatic readback_all(input string name);
        build_model();
        for (int c = 0; c < C; c++)
            for (int r = 0; r < OD; r++)
                for (int k = 0; k < OD; k++)
                    read_check(c, r, k, exp_mem[c][r][k], name);
        read_check(1, 2, 0, 64'd0, {name, "_oob"});
    endtask

    // k counts cycles after the edge that accepts compute.
    task automatic run_pool(input int pulse_at, input int reset_at, input string name);
        @(negedge clk);
        compute = 1'b1;
        for (int k = 1; k <= N + 3; k++) begin
            @(negedge clk);
            compute = 1'b0;
            if (k == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check({name, "_rst_busy"}, 64'(busy), 64'd0);
                check({name, "_rst_valid"}, 64'(output_valid), 64'd0);
                check({name, "_rst_idx"}, 64'(read_inmem_index), 64'd0);
                return;
            end
            check({name, "_busy"}, 64'(busy), 64'(k <= N + 1));
            check({name, "_valid"}, 64'(output_valid), 64'(k >= N + 2));
            if (k <= N)
                check({name, "_idx"}, 64'(read_inmem_index), 64'(exp_idx[k-1]));
            if (k == pulse_at)
                compute = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1;
        compute = 1'b0;
        in_data = 64'd0;
        read_outmem_index = '0;

        for (int c = 0; c < C; c++)
            for (int r = 0; r < OD; r++)
                for (int k = 0; k < OD; k++)
                    for (int wr = 0; wr < P; wr++)
                        for (int wc = 0; wc < P; wc++)
                            exp_idx.push_back({16'(c), 16'(r*P+wr), 16'(k*P+wc)});

        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_valid", 64'(output_valid), 64'd0);
        check("reset_out", out_data, 64'd0);
        check("reset_idx", 64'(read_inmem_index), 64'd0);

        // Ramp data; trailing row/col hold a huge value that would surface if read.
        for (int c = 0; c < C; c++)
            for (int r = 0; r < D; r++)
                for (int k = 0; k < D; k++)
                    up_mem[c][r][k] = (r == D-1 || k == D-1) ? $realtobits(1.0e9)
                                                              : $realtobits(real'(r*4 + k + 100*c));
        run_pool(0, 0, "ramp");
        vecs = '{
            '{0, 0, 0, $realtobits(5.0),   "ramp_c0_00"},
            '{0, 0, 1, $realtobits(7.0),   "ramp_c0_01"},
            '{0, 1, 0, $realtobits(13.0),  "ramp_c0_10"},
            '{0, 1, 1, $realtobits(15.0),  "ramp_c0_11"},
            '{1, 0, 0, $realtobits(105.0), "ramp_c1_00"},
            '{1, 1, 1, $realtobits(115.0), "ramp_c1_11"},
            '{1, 2, 0, 64'd0,              "oob_row"},
            '{2, 0, 0, 64'd0,              "oob_chan"},
            '{0, 0, 2, 64'd0,              "oob_col"}
        };
        foreach (vecs[i])
            read_check(vecs[i].c, vecs[i].r, vecs[i].col, vecs[i].exp, vecs[i].name);

        run_pool(5, 0, "midpulse");
        readback_all("midpulse_data");
        check("done_valid_held", 64'(output_valid), 64'd1);
        run_pool(0, 0, "donepulse");
        readback_all("donepulse_data");

        fill_random();
        up_mem[0][0][0] = $realtobits(-1.0);
        up_mem[0][0][1] = $realtobits(-0.5);
        up_mem[0][1][0] = $realtobits(-2.0);
        up_mem[0][1][1] = $realtobits(-3.0);
        up_mem[0][0][2] = 64'h8000_0000_0000_0000;
        up_mem[0][0][3] = 64'h0000_0000_0000_0000;
        up_mem[0][1][2] = $realtobits(-1.0);
        up_mem[0][1][3] = $realtobits(-1.0);
        up_mem[0][2][0] = 64'h7FF0_0000_0000_0000;
        up_mem[0][2][1] = $realtobits(1.0);
        up_mem[0][3][0] = $realtobits(2.0);
        up_mem[0][3][1] = $realtobits(3.0);
        run_pool(0, 0, "signmix");
        vecs = '{
            '{0, 0, 0, 64'hBFE0_0000_0000_0000, "neg_half"},
            '{0, 0, 1, 64'h8000_0000_0000_0000, "negzero_tie"},
            '{0, 1, 0, 64'h7FF0_0000_0000_0000, "pos_inf"}
        };
        foreach (vecs[i])
            read_check(vecs[i].c, vecs[i].r, vecs[i].col, vecs[i].exp, vecs[i].name);
        readback_all("signmix_data");

        fill_random();
        run_pool(0, 7, "abort");
        run_pool(0, 0, "after_abort");
        readback_all("after_abort_data");

        for (int it = 0; it < 3; it++) begin
            fill_random();
            run_pool(0, 0, "random");
            readback_all("random_data");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
